// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings for the load/store unit: access sizes,
//               FSM states and byte-lane strobe patterns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B0   = 4'b0001;
    localparam logic [3:0] STRB_HLO  = 4'b0011;
    localparam logic [3:0] STRB_HHI  = 4'b1100;
    localparam logic [3:0] STRB_W    = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Combinational store lane replication / strobe generation and
//               load byte-lane extraction with sign or zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wstrb = STRB_NONE;
        o_wdata = i_wdata;
        case (i_size)
            SIZE_B: begin
                o_wstrb = STRB_B0 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SIZE_H: begin
                o_wstrb = i_lane[1] ? STRB_HHI : STRB_HLO;
                o_wdata = {2{i_wdata[15:0]}};
            end
            SIZE_W: begin
                o_wstrb = STRB_W;
                o_wdata = i_wdata;
            end
            default: begin
                o_wstrb = STRB_NONE;
                o_wdata = i_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (i_lane)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_load = i_rdata;
        case (i_size)
            SIZE_B:  o_load = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SIZE_H:  o_load = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default: o_load = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Single-transaction data-memory access engine: validates the
//               decoded request, runs one req/ack bus cycle, reports status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        data_r,
    input  logic        data_w,
    input  logic [1:0]  data_size,
    input  logic        unsigned_value,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    localparam bit                   C_TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam int                   C_TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_WIDTH-1:0] C_TO_LAST   = C_TO_LAST_I[CNT_WIDTH-1:0];

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_addr;
    logic [1:0]             r_size;
    logic                   r_uns;
    logic                   r_we;
    logic [31:0]            r_wdata;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_mis;
    logic                   r_berr;
    logic [31:0]            r_rdata;

    logic                   w_cmd_bad;
    logic                   w_align_bad;
    logic                   w_timeout;
    logic [3:0]             w_wstrb;
    logic [31:0]            w_wdata;
    logic [31:0]            w_load;

    assign w_cmd_bad   = (data_r == data_w);
    assign w_align_bad = (data_size == SIZE_ILL)
                       | ((data_size == SIZE_H) & addr[0])
                       | ((data_size == SIZE_W) & (addr[1:0] != 2'b00));
    assign w_timeout   = C_TO_EN && (r_cnt == C_TO_LAST);

    lsu_align u_align (
        .i_size     (r_size),
        .i_lane     (r_addr[1:0]),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .i_rdata    (mem_rdata),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_load     (w_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (w_cmd_bad || w_align_bad) ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_ack || w_timeout) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_mis   <= 1'b0;
            r_berr  <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Command fault outranks alignment fault.
                        r_berr <= w_cmd_bad;
                        r_mis  <= ~w_cmd_bad & w_align_bad;
                        r_cnt  <= '0;
                        if (!w_cmd_bad && !w_align_bad) begin
                            r_addr  <= addr;
                            r_size  <= data_size;
                            r_uns   <= unsigned_value;
                            r_we    <= data_w;
                            r_wdata <= wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        r_berr <= mem_err;
                        if (!r_we && !mem_err) begin
                            r_rdata <= w_load;
                        end
                    end else if (w_timeout) begin
                        r_berr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state == REQ) || (r_state == RESP);
    assign done       = (r_state == RESP);
    assign misaligned = done & r_mis;
    assign bus_error  = done & r_berr;
    assign rdata      = r_rdata;
    assign mem_req    = (r_state == REQ);
    assign mem_we     = mem_req & r_we;
    assign mem_addr   = {r_addr[31:2], 2'b00};
    assign mem_wstrb  = mem_we ? w_wstrb : STRB_NONE;
    assign mem_wdata  = w_wdata;

endmodule

`default_nettype wire
